// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and RX state encoding shared by the PS/2 receiver files.
//   PS2_BREAK      - break (key release) prefix byte
//   PS2_EXT        - extended key prefix byte
//   PS2_FRAME_BITS - start + 8 data + parity + stop
package ps2_pkg;
   localparam logic [7:0] PS2_BREAK      = 8'hF0;
   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam int         PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } rx_state_t;
endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: two-flop synchronizers for ps2_clk/ps2_data, a glitch filter
// on the clock and a one-cycle pulse on each filtered falling edge.
//   clk, reset - system clock, synchronous active-high reset
//   ps2_clk    - raw PS/2 clock (asynchronous)
//   ps2_data   - raw PS/2 data (asynchronous)
//   data_s     - synchronized ps2_data
//   fall_tick  - registered pulse on a filtered 1->0 clock transition
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_s,
   output logic fall_tick
);
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          filt;
   logic [CW-1:0] cnt;

   assign data_s = data_sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         filt      <= 1'b1;
         cnt       <= '0;
         fall_tick <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
         fall_tick <= 1'b0;
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            // FILTER_LEN-th consecutive disagreeing sample: accept the new level.
            // A flip away from 1 is a falling edge.
            filt      <= clk_sync[1];
            cnt       <= '0;
            fall_tick <= filt;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver. Deframes device-to-host frames, checks
// odd parity and stop bit, strips F0/E0 prefixes and presents one make code
// per key press.
//   clk, reset - system clock, synchronous active-high reset
//   ps2_clk    - raw PS/2 clock from connector
//   ps2_data   - raw PS/2 data from connector
//   key_code   - last accepted make code, held until the next accept
//   key_ext    - make code was preceded by E0, held with key_code
//   key_valid  - one-cycle pulse when key_code/key_ext update
//   frame_err  - one-cycle pulse on start, parity, stop or timeout error
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_valid,
   output logic       frame_err
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic          data_s;
   logic          fall_tick;
   rx_state_t     state, state_nx;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] to_cnt;
   logic          brk_flag, ext_flag;
   logic          start_err, to_err, chk_good, chk_bad;
   logic          frame_ok;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .data_s    (data_s),
      .fall_tick (fall_tick)
   );

   // shreg[7:0] data (LSB first), shreg[8] parity, shreg[9] stop
   assign frame_ok = (^shreg[8:0]) & shreg[9];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      start_err = 1'b0;
      to_err    = 1'b0;
      chk_good  = 1'b0;
      chk_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (fall_tick) begin
               if (!data_s) state_nx  = SHIFT;
               else         start_err = 1'b1;
            end
         end
         SHIFT: begin
            if (fall_tick) begin
               if (bit_cnt == 4'd9) state_nx = CHECK;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               to_err   = 1'b1;
               state_nx = IDLE;
            end
         end
         CHECK: begin
            state_nx = IDLE;
            if (frame_ok) chk_good = 1'b1;
            else          chk_bad  = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt   <= '0;
         shreg     <= '0;
         to_cnt    <= '0;
         brk_flag  <= 1'b0;
         ext_flag  <= 1'b0;
         key_code  <= 8'h00;
         key_ext   <= 1'b0;
         key_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= start_err | to_err | chk_bad;

         if (state == IDLE) begin
            bit_cnt <= '0;
            to_cnt  <= '0;
         end else if (state == SHIFT) begin
            if (fall_tick) begin
               shreg   <= {data_s, shreg[9:1]};
               bit_cnt <= bit_cnt + 1'b1;
               to_cnt  <= '0;
            end else begin
               to_cnt  <= to_cnt + 1'b1;
            end
         end

         // Prefix flags survive timeouts and bad frames; only a completed
         // release sequence or a delivered make code clears them.
         if (chk_good) begin
            if (shreg[7:0] == PS2_BREAK) begin
               brk_flag <= 1'b1;
            end else if (shreg[7:0] == PS2_EXT) begin
               ext_flag <= 1'b1;
            end else if (brk_flag) begin
               brk_flag <= 1'b0;
               ext_flag <= 1'b0;
            end else begin
               key_code  <= shreg[7:0];
               key_ext   <= ext_flag;
               key_valid <= 1'b1;
               ext_flag  <= 1'b0;
            end
         end
      end
   end
endmodule
